// File: rtl/nf_merge_arb_pkg.sv
// Shared types for the two-channel packet merge arbiter.
package nf_merge_arb_pkg;

  localparam int STATS_W = 32;
  localparam int EMPTY_W = 6;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  port;
    logic [7:0]  flags;
  } metadata_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

// File: rtl/nf_merge_arb_if.sv
// Avalon-ST style stream: valid/ready handshake with sop/eop/empty framing.
interface avl_stream_if #(
    parameter int W  = 8,
    parameter int EW = nf_merge_arb_pkg::EMPTY_W
);
    logic          valid;
    logic          ready;
    logic [W-1:0]  data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;

    modport tx (output valid, data, sop, eop, empty, input ready);
    modport rx (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/nf_merge_arb_rr_arb2.sv
// Two-way round-robin pick: on a tie the channel not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_sel,
    output logic       gnt
);
    always_comb begin
        gnt = 1'b0;
        if (&req)
            gnt = ~last_sel;
        else if (req[1])
            gnt = 1'b1;
    end
endmodule

// File: rtl/nf_merge_arb.sv
// Merges two meta+packet streams into one, a whole packet at a time.
module nf_merge_arb
    import nf_merge_arb_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int META_W = $bits(metadata_t)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    avl_stream_if.rx           in0_pkt,
    avl_stream_if.rx           in0_meta,
    avl_stream_if.rx           in1_pkt,
    avl_stream_if.rx           in1_meta,
    avl_stream_if.tx           out_pkt,
    avl_stream_if.tx           out_meta,
    output logic [STATS_W-1:0] stats_pkt0,
    output logic [STATS_W-1:0] stats_pkt1,
    output logic [STATS_W-1:0] stats_conflict
);
    state_t state;
    logic   sel, last_sel, meta_done, eop_seen;
    logic   arb_sel, xfer, pkt_open;
    logic   sm_valid, sp_valid, sp_eop;
    logic   meta_hs, eop_hs, done;
    logic [1:0]        req;
    logic [DATA_W-1:0] pkt_data_sel;
    logic [META_W-1:0] meta_data_sel;

    assign req = {in1_meta.valid, in0_meta.valid};

    rr_arb2 u_arb (
        .req      (req),
        .last_sel (last_sel),
        .gnt      (arb_sel)
    );

    assign xfer     = (state == XFER);
    // Once eop has been taken, further beats belong to the next packet.
    assign pkt_open = xfer & ~eop_seen;

    assign sm_valid      = sel ? in1_meta.valid : in0_meta.valid;
    assign sp_valid      = sel ? in1_pkt.valid  : in0_pkt.valid;
    assign sp_eop        = sel ? in1_pkt.eop    : in0_pkt.eop;
    assign pkt_data_sel  = sel ? in1_pkt.data   : in0_pkt.data;
    assign meta_data_sel = sel ? in1_meta.data  : in0_meta.data;

    assign meta_hs = xfer & ~meta_done & sm_valid & out_meta.ready;
    assign eop_hs  = pkt_open & sp_valid & sp_eop & out_pkt.ready;
    assign done    = xfer & (eop_hs | eop_seen) & (meta_hs | meta_done);

    assign out_meta.valid = xfer & ~meta_done & sm_valid;
    assign out_meta.data  = meta_data_sel;
    assign out_meta.sop   = sel ? in1_meta.sop   : in0_meta.sop;
    assign out_meta.eop   = sel ? in1_meta.eop   : in0_meta.eop;
    assign out_meta.empty = sel ? in1_meta.empty : in0_meta.empty;
    assign in0_meta.ready = xfer & ~meta_done & ~sel & out_meta.ready;
    assign in1_meta.ready = xfer & ~meta_done &  sel & out_meta.ready;

    assign out_pkt.valid  = pkt_open & sp_valid;
    assign out_pkt.data   = pkt_data_sel;
    assign out_pkt.sop    = sel ? in1_pkt.sop   : in0_pkt.sop;
    assign out_pkt.eop    = sp_eop;
    assign out_pkt.empty  = sel ? in1_pkt.empty : in0_pkt.empty;
    assign in0_pkt.ready  = pkt_open & ~sel & out_pkt.ready;
    assign in1_pkt.ready  = pkt_open &  sel & out_pkt.ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            sel            <= 1'b0;
            last_sel       <= 1'b1;
            meta_done      <= 1'b0;
            eop_seen       <= 1'b0;
            stats_pkt0     <= '0;
            stats_pkt1     <= '0;
            stats_conflict <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= arb_sel;
                        state <= XFER;
                        if (&req)
                            stats_conflict <= stats_conflict + STATS_W'(1);
                    end
                end
                XFER: begin
                    if (done) begin
                        state     <= IDLE;
                        last_sel  <= sel;
                        meta_done <= 1'b0;
                        eop_seen  <= 1'b0;
                        if (sel)
                            stats_pkt1 <= stats_pkt1 + STATS_W'(1);
                        else
                            stats_pkt0 <= stats_pkt0 + STATS_W'(1);
                    end else begin
                        if (meta_hs) meta_done <= 1'b1;
                        if (eop_hs)  eop_seen  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nf_merge_arb.sv
// Directed scoreboard bench for nf_merge_arb.
module tb_nf_merge_arb;
    import nf_merge_arb_pkg::*;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } beat_t;

    logic Clk, Rst_n;
    logic [31:0] stats_pkt0, stats_pkt1, stats_conflict;

    avl_stream_if #(.W(512)) in0_pkt ();
    avl_stream_if #(.W(32))  in0_meta ();
    avl_stream_if #(.W(512)) in1_pkt ();
    avl_stream_if #(.W(32))  in1_meta ();
    avl_stream_if #(.W(512)) out_pkt ();
    avl_stream_if #(.W(32))  out_meta ();

    nf_merge_arb #(.DATA_W(512)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .in0_pkt        (in0_pkt),
        .in0_meta       (in0_meta),
        .in1_pkt        (in1_pkt),
        .in1_meta       (in1_meta),
        .out_pkt        (out_pkt),
        .out_meta       (out_meta),
        .stats_pkt0     (stats_pkt0),
        .stats_pkt1     (stats_pkt1),
        .stats_conflict (stats_conflict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    metadata_t mq[2][$];
    beat_t     pq[2][$];
    metadata_t exp_m[$];
    beat_t     exp_b[$];
    logic      m_valid[2];
    logic      p_valid[2];
    metadata_t m_data[2];
    beat_t     p_beat[2];
    logic [1:0] m_rdy, p_rdy;
    logic op_ready, om_ready, sb_on, chk1;
    int checks = 0, errors = 0, nbeats_out = 0;

    assign in0_meta.valid = m_valid[0];
    assign in0_meta.data  = m_data[0];
    assign in0_meta.sop   = 1'b0;
    assign in0_meta.eop   = 1'b0;
    assign in0_meta.empty = '0;
    assign in1_meta.valid = m_valid[1];
    assign in1_meta.data  = m_data[1];
    assign in1_meta.sop   = 1'b0;
    assign in1_meta.eop   = 1'b0;
    assign in1_meta.empty = '0;
    assign in0_pkt.valid  = p_valid[0];
    assign in0_pkt.data   = p_beat[0].data;
    assign in0_pkt.sop    = p_beat[0].sop;
    assign in0_pkt.eop    = p_beat[0].eop;
    assign in0_pkt.empty  = p_beat[0].empty;
    assign in1_pkt.valid  = p_valid[1];
    assign in1_pkt.data   = p_beat[1].data;
    assign in1_pkt.sop    = p_beat[1].sop;
    assign in1_pkt.eop    = p_beat[1].eop;
    assign in1_pkt.empty  = p_beat[1].empty;
    assign out_pkt.ready  = op_ready;
    assign out_meta.ready = om_ready;
    assign m_rdy = {in1_meta.ready, in0_meta.ready};
    assign p_rdy = {in1_pkt.ready, in0_pkt.ready};

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each source presents its queue head and pops it on a sampled handshake.
    task automatic drive(input int ch);
        forever begin
            @(posedge Clk);
            #1;
            m_valid[ch] = (mq[ch].size() != 0);
            if (mq[ch].size() != 0) m_data[ch] = mq[ch][0];
            p_valid[ch] = (pq[ch].size() != 0);
            if (pq[ch].size() != 0) p_beat[ch] = pq[ch][0];
            @(negedge Clk);
            if (Rst_n && m_valid[ch] && m_rdy[ch] && mq[ch].size() != 0) void'(mq[ch].pop_front());
            if (Rst_n && p_valid[ch] && p_rdy[ch] && pq[ch].size() != 0) void'(pq[ch].pop_front());
        end
    endtask

    task automatic send(input int ch, input int n, input logic [5:0] emp, input bit expect_out);
        metadata_t m;
        beat_t     b;
        m = '{len: 16'(n * 64), port: 8'(ch), flags: 8'($urandom_range(0, 255))};
        mq[ch].push_back(m);
        if (expect_out) exp_m.push_back(m);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = $urandom;
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = (i == n - 1) ? emp : 6'd0;
            pq[ch].push_back(b);
            if (expect_out) exp_b.push_back(b);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_m.size() != 0 || exp_b.size() != 0) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_drain"}, n < 3000, 1'b1);
        repeat (3) @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (out_meta.valid && out_meta.ready && sb_on) begin
                if (exp_m.size() == 0) chk("meta_extra", out_meta.data, '0);
                else chk("meta", out_meta.data, exp_m.pop_front());
            end
            if (out_pkt.valid && out_pkt.ready) begin
                nbeats_out++;
                if (sb_on) begin
                    if (exp_b.size() == 0) chk("beat_extra", 1'b1, 1'b0);
                    else chk("beat", {out_pkt.data, out_pkt.sop, out_pkt.eop, out_pkt.empty},
                             exp_b.pop_front());
                end
            end
            if (chk1) chk("ch1_ready", {in1_pkt.ready, in1_meta.ready}, 2'b00);
        end
    end

    initial begin
        int n0;
        Rst_n = 1'b0;
        op_ready = 1'b1;
        om_ready = 1'b1;
        sb_on = 1'b1;
        chk1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_valid[c] = 1'b0;
            p_valid[c] = 1'b0;
            m_data[c]  = '0;
            p_beat[c]  = '0;
        end
        fork
            drive(0);
            drive(1);
        join_none

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_valid", {out_pkt.valid, out_meta.valid}, 2'b00);
        chk("rst_ready", {in0_pkt.ready, in0_meta.ready, in1_pkt.ready, in1_meta.ready}, 4'b0);
        chk("rst_stats", {stats_pkt0, stats_pkt1, stats_conflict}, 96'd0);
        chk("rst_regs", {dut.state, dut.sel, dut.last_sel, dut.meta_done}, {IDLE, 1'b0, 1'b1, 1'b0});
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single 3-beat ch0 packet, empty=5 on eop
        send(0, 3, 6'd5, 1'b1);
        wait_idle("single");
        chk("single_pkt0", stats_pkt0, 32'd1);

        // 1-beat packet: meta and sop/eop beat handshake together
        n0 = nbeats_out;
        send(0, 1, 6'd3, 1'b1);
        for (int i = 0; i < 50 && nbeats_out == n0; i++) @(negedge Clk);
        chk("one_beat_seen", nbeats_out, n0 + 1);
        @(negedge Clk);
        chk("one_beat_idle", {dut.state, in0_pkt.ready, in0_meta.ready, out_pkt.valid}, {IDLE, 3'b000});
        wait_idle("one_beat");
        chk("one_beat_pkt0", stats_pkt0, 32'd2);

        // 5-beat packet with out_pkt.ready toggling 1010
        chk1 = 1'b1;
        send(0, 5, 6'd1, 1'b1);
        for (int i = 0; i < 200 && exp_b.size() != 0; i++) begin
            @(posedge Clk);
            #1 op_ready = ~op_ready;
        end
        op_ready = 1'b1;
        wait_idle("toggle");
        chk1 = 1'b0;
        chk("toggle_pkt0", stats_pkt0, 32'd3);

        // Counter wrap
        @(negedge Clk);
        force dut.stats_pkt0 = 32'hFFFF_FFFF;
        @(negedge Clk);
        release dut.stats_pkt0;
        @(negedge Clk);
        chk("wrap_pre", stats_pkt0, 32'hFFFF_FFFF);
        send(0, 2, 6'd0, 1'b1);
        wait_idle("wrap");
        chk("wrap_post", stats_pkt0, 32'd0);

        // Reset during the 2nd beat of a 4-beat ch1 packet
        sb_on = 1'b0;
        n0 = nbeats_out;
        send(1, 4, 6'd2, 1'b0);
        for (int i = 0; i < 50 && nbeats_out == n0; i++) @(negedge Clk);
        chk("abort_first_beat", nbeats_out, n0 + 1);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("abort_valid", {out_pkt.valid, out_meta.valid}, 2'b00);
        chk("abort_ready", {in0_pkt.ready, in0_meta.ready, in1_pkt.ready, in1_meta.ready}, 4'b0);
        chk("abort_stats", {stats_pkt0, stats_pkt1, stats_conflict}, 96'd0);
        chk("abort_regs", {dut.state, dut.sel, dut.last_sel, dut.meta_done, dut.eop_seen},
            {IDLE, 1'b0, 1'b1, 2'b00});
        mq[1].delete();
        pq[1].delete();
        m_valid[1] = 1'b0;
        p_valid[1] = 1'b0;
        @(negedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        sb_on = 1'b1;
        repeat (2) @(negedge Clk);

        // Both channels continuously requesting: strict alternation from ch0
        for (int k = 0; k < 4; k++) begin
            send(0, 1 + k, 6'(k), 1'b1);
            send(1, 4 - k, 6'(k + 8), 1'b1);
        end
        wait_idle("alt");
        chk("alt_pkt0", stats_pkt0, 32'd4);
        chk("alt_pkt1", stats_pkt1, 32'd4);
        chk("alt_conflict", stats_conflict, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nf_merge_arb.md
NF_MERGE_ARB -- requirements
Module: nf_merge_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DATA_W, 512, packet data width
  META_W, $bits(metadata_t), metadata width
REQ-002 Ports SHALL be (name, direction, width, meaning):
  Clk  in  1  sole clock
  Rst_n  in  1  reset; one clock; asynchronous, active-low
  in0_pkt / in0_meta  avl_stream_if.rx  DATA_W / META_W  channel 0 (NF-checked traffic)
  in1_pkt / in1_meta  avl_stream_if.rx  DATA_W / META_W  channel 1 (bypass traffic)
  out_pkt / out_meta  avl_stream_if.tx  DATA_W / META_W  merged stream
  stats_pkt0, stats_pkt1  out  32  packets forwarded from channel 0 and channel 1
  stats_conflict  out  32  grant cycles where both channels requested
REQ-003 Each packet SHALL be one meta beat plus one or more pkt beats (sop first, eop last); data, sop, eop and empty SHALL pass through unmodified.

Function
REQ-004 A channel SHALL request when its in_meta.valid=1.
REQ-005 The FSM SHALL have states IDLE, XFER.
REQ-006 In IDLE, if any channel requests, the FSM SHALL latch sel (round-robin: the channel not served last wins a tie; channel 0 wins the first tie after reset) and go to XFER next cycle; with no request it SHALL stay in IDLE.
REQ-007 In IDLE, all in*.ready SHALL be 0 and out*.valid SHALL be 0.
REQ-008 In XFER, out_meta SHALL mirror in<sel>_meta (valid, data, ready) until one meta handshake; meta_done SHALL then be set and out_meta.valid SHALL be forced to 0.
REQ-009 In XFER, out_pkt SHALL mirror in<sel>_pkt combinationally (zero-cycle latency, ready from out_pkt.ready); the unselected channel's ready SHALL be 0.
REQ-010 XFER SHALL return to IDLE on the cycle when the eop handshake has occurred and meta_done is set; both events in the same cycle SHALL count.
REQ-011 On leaving XFER, last_sel SHALL be updated to sel, meta_done SHALL clear, and stats_pkt<sel> SHALL increment.
REQ-012 A pkt beat with sop=1 and eop=1 SHALL be a complete packet.
REQ-013 A pkt beat with sop=1 while in XFER after a prior sop without eop SHALL be forwarded unchanged; no recovery.
REQ-014 Minimum per-packet overhead SHALL be one IDLE cycle; back-to-back packets alternate channels when both request.
REQ-015 stats_conflict SHALL increment on each IDLE->XFER transition where both channels request.
REQ-016 All counters SHALL be 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-017 A channel whose meta is held off SHALL be served within one packet of the other channel.

Reset
REQ-018 While Rst_n=0, the FSM SHALL be IDLE, sel=0, last_sel=1, meta_done=0, all counters 0, all ready/valid outputs 0.
REQ-019 Reset asserted mid-XFER SHALL abort the packet; no partial packet state SHALL survive.

Structure
REQ-020 The state enum and the STATS_W=32 constant SHALL live in the shared struct package; metadata_t SHALL be reused unchanged.
REQ-021 One sub-module, rr_arb2 (2-way round-robin with last_sel input), SHALL be instantiated.

Verification
REQ-022 Single packet on ch0 (meta M0, 3 beats, empty=5 on eop) -> out shows M0 then 3 beats identical; stats_pkt0=1.
REQ-023 Both channels request continuously, 4 packets each -> output order ch0,ch1,ch0,ch1,...; stats_conflict=7, stats_pkt0=stats_pkt1=4.
REQ-024 out_pkt.ready toggles 1010 during a 5-beat packet -> no beat is lost or duplicated; ch1 ready stays 0 throughout.
REQ-025 A 1-beat packet (sop=eop=1) with meta handshake in the same cycle as eop -> return to IDLE next cycle.
REQ-026 Rst_n asserted on the 2nd beat of a 4-beat ch1 packet -> all outputs 0 immediately; after release, ch0 wins the first tie.
REQ-027 Preload stats_pkt0=0xFFFFFFFF via force, send one ch0 packet -> stats_pkt0=0.
